// File: rtl/edic_bus_receiver.sv
// Receiver for a 74x540-style inverting bus driver: settle filter, one capture per enable window, FWFT FIFO.
// Define EDIC_BUS_PARITY_CHECK_EN to add the bus_par_n input and out_par_err output.
module edic_bus_receiver #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         bus_n,
    input  logic                     oe1_n,
    input  logic                     oe2_n,
`ifdef EDIC_BUS_PARITY_CHECK_EN
    input  logic                     bus_par_n,
    output logic                     out_par_err,
`endif
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(SETTLE + 1);
`ifdef EDIC_BUS_PARITY_CHECK_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    logic [WIDTH-1:0] bus_n_p0;
    logic             oe1_n_p0;
    logic             oe2_n_p0;
    logic             active_p0;
    logic [EW-1:0]    word_p0;
`ifdef EDIC_BUS_PARITY_CHECK_EN
    logic             par_n_p0;
`endif

    state_t           state;
    state_t           state_next;
    logic [NW-1:0]    cnt;
    logic [NW-1:0]    cnt_next;
    logic [EW-1:0]    cand;
    logic [EW-1:0]    cand_next;
    logic             push;

    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [EW-1:0]    head;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic             drop;

`ifdef EDIC_BUS_PARITY_CHECK_EN
    function automatic logic odd_parity(input logic [EW-1:0] w);
        return ^w;
    endfunction
`endif

    // s-stage: bus and enables registered once; idles as an inactive, all-ones bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_n_p0 <= '1;
            oe1_n_p0 <= 1'b1;
            oe2_n_p0 <= 1'b1;
`ifdef EDIC_BUS_PARITY_CHECK_EN
            par_n_p0 <= 1'b1;
`endif
        end else begin
            bus_n_p0 <= bus_n;
            oe1_n_p0 <= oe1_n;
            oe2_n_p0 <= oe2_n;
`ifdef EDIC_BUS_PARITY_CHECK_EN
            par_n_p0 <= bus_par_n;
`endif
        end
    end

    assign active_p0 = !oe1_n_p0 && !oe2_n_p0;
`ifdef EDIC_BUS_PARITY_CHECK_EN
    assign word_p0 = {~par_n_p0, ~bus_n_p0};
`else
    assign word_p0 = ~bus_n_p0;
`endif

    // settle filter: one capture per enable window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        push       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (active_p0) begin
                    cand_next = word_p0;
                    cnt_next  = NW'(1);
                    if (SETTLE == 1) begin
                        push       = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        state_next = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!active_p0) begin
                    state_next = ST_IDLE;
                end else if (word_p0 != cand) begin
                    cand_next = word_p0;
                    cnt_next  = NW'(1);
                end else begin
                    cnt_next = cnt + NW'(1);
                    if (cnt + NW'(1) == NW'(SETTLE)) begin
                        push       = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!active_p0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FIFO: a push into a full FIFO still lands when the head leaves on the same edge
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && (!full || pop);
    assign drop      = push && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= cand_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    assign head     = mem[rd_ptr];
    assign out_data = out_valid ? head[WIDTH-1:0] : '0;
`ifdef EDIC_BUS_PARITY_CHECK_EN
    assign out_par_err = out_valid && !odd_parity(head);
`endif

endmodule

// File: tb/tb_edic_bus_receiver.sv
// Scoreboard bench for edic_bus_receiver: window-level reference model feeds an expected-word queue
// that a negedge monitor checks against the FIFO head, count and overflow.
module tb_edic_bus_receiver;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_n = 8'hFF;
    logic       oe1_n = 1'b1;
    logic       oe2_n = 1'b1;
    logic       out_ready = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] count;
    logic       overflow;
`ifdef EDIC_BUS_PARITY_CHECK_EN
    logic       bus_par_n;
    logic       out_par_err;
    assign bus_par_n = ^(~bus_n);
`endif

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb_q[$];
    int         m_count = 0;
    bit         m_ovf = 1'b0;

    always #5 clk = ~clk;

    edic_bus_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk),
        .rst(rst),
        .bus_n(bus_n),
        .oe1_n(oe1_n),
        .oe2_n(oe2_n),
`ifdef EDIC_BUS_PARITY_CHECK_EN
        .bus_par_n(bus_par_n),
        .out_par_err(out_par_err),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a capture happens once SETTLE consecutive identical samples have been
    // seen inside one enable window; the decision lands one edge after the last such sample.
    initial begin : model
        bit         act_s;
        logic [7:0] bus_s;
        int         run;
        logic [7:0] val;
        bit         done;
        bit         push;
        bit         pop;
        bit         drop;
        act_s = 1'b0; bus_s = 8'hFF; run = 0; val = 8'h00; done = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                act_s = 1'b0; bus_s = 8'hFF; run = 0; done = 1'b0;
                m_count = 0; m_ovf = 1'b0;
                sb_q.delete();
            end else begin
                push = 1'b0;
                if (!act_s) begin
                    run = 0;
                    done = 1'b0;
                end else begin
                    if (run > 0 && ~bus_s == val) run++;
                    else begin
                        run = 1;
                        val = ~bus_s;
                    end
                    if (!done && run >= SETTLE) begin
                        push = 1'b1;
                        done = 1'b1;
                    end
                end
                pop  = (m_count > 0) && out_ready;
                drop = push && (m_count == DEPTH) && !pop;
                if (push && !drop) sb_q.push_back(val);
                m_count = m_count + ((push && !drop) ? 1 : 0) - (pop ? 1 : 0);
                if (drop) m_ovf = 1'b1;
                else if (clr_overflow) m_ovf = 1'b0;
                act_s = !oe1_n && !oe2_n;
                bus_s = bus_n;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            check("valid", out_valid, m_count != 0);
            check("count", count, m_count);
            check("overflow", overflow, m_ovf);
`ifdef EDIC_BUS_PARITY_CHECK_EN
            check("par_err", out_par_err, 1'b0);
`endif
            if (!out_valid) begin
                check("empty_data", out_data, 8'h00);
            end else if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL head: got %0h expected no word at %0t", out_data, $time);
            end else if (out_ready) begin
                check("pop_data", out_data, sb_q.pop_front());
            end else begin
                check("head_data", out_data, sb_q[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a1, input logic a2, input logic [7:0] b);
        oe1_n = a1;
        oe2_n = a2;
        bus_n = b;
    endtask

    task automatic idle(input int n);
        drive(1'b1, 1'b1, 8'hFF);
        repeat (n) step();
    endtask

    task automatic window(input logic [7:0] val, input int len);
        drive(1'b0, 1'b0, ~val);
        repeat (len) step();
        drive(1'b1, 1'b1, 8'hFF);
    endtask

    // window whose capture edge also carries the given out_ready / clr_overflow levels
    task automatic window_hit(input logic [7:0] val, input logic rdy, input logic clr);
        drive(1'b0, 1'b0, ~val);
        step();
        step();
        out_ready = rdy;
        clr_overflow = clr;
        step();
        out_ready = 1'b0;
        clr_overflow = 1'b0;
        drive(1'b1, 1'b1, 8'hFF);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    initial begin : stim
        bit         act;
        logic [7:0] val;
        int         r;

        step();
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_count", count, 3'd0);
        check("rst_data", out_data, 8'h00);
        check("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        idle(2);

        // latency and single capture
        drive(1'b0, 1'b0, 8'hA5);
        step();
        step();
        check("lat_e1_valid", out_valid, 1'b0);
        step();
        check("lat_e2_valid", out_valid, 1'b1);
        check("lat_e2_data", out_data, 8'h5A);
        check("lat_e2_count", count, 3'd1);
        step();
        idle(3);
        check("one_capture", count, 3'd1);
        drain(2);

        // glitch windows
        window(8'h33, 1);
        idle(3);
        check("short_window", count, 3'd0);
        drive(1'b0, 1'b1, 8'h11);
        repeat (4) step();
        idle(2);
        check("half_enable", count, 3'd0);

        // settle restart on a data change
        drive(1'b0, 1'b0, 8'h00);
        step();
        drive(1'b0, 1'b0, 8'h0F);
        repeat (3) step();
        idle(2);
        check("restart_count", count, 3'd1);
        check("restart_data", out_data, 8'hF0);
        drain(2);

        // overflow, set-wins-over-clear, ordered drain
        for (int i = 1; i <= 5; i++) begin
            window(8'(i * 8'h11), 3);
            idle(1);
        end
        idle(1);
        check("full_count", count, 3'd4);
        check("full_ovf", overflow, 1'b1);
        window_hit(8'h66, 1'b0, 1'b1);
        check("set_wins", overflow, 1'b1);
        idle(2);
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        check("ovf_cleared", overflow, 1'b0);
        check("order_head", out_data, 8'h11);
        drain(6);
        check("drained", count, 3'd0);

        // push and pop on the same edge while full
        for (int i = 1; i <= 4; i++) begin
            window(8'(8'h80 + i), 3);
            idle(1);
        end
        window_hit(8'h85, 1'b1, 1'b0);
        check("full_pp_count", count, 3'd4);
        check("full_pp_ovf", overflow, 1'b0);
        check("full_pp_head", out_data, 8'h82);
        idle(2);
        drain(6);

        // asynchronous reset mid-settle
        window(8'hC1, 3);
        idle(1);
        window(8'hC2, 3);
        idle(1);
        check("pre_rst_count", count, 3'd2);
        drive(1'b0, 1'b0, ~8'hC3);
        step();
        step();
        rst = 1'b1;
        #1;
        check("async_valid", out_valid, 1'b0);
        check("async_data", out_data, 8'h00);
        check("async_count", count, 3'd0);
        check("async_ovf", overflow, 1'b0);
        drive(1'b1, 1'b1, 8'hFF);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, ~8'h3C);
        step();
        step();
        check("post_rst_e1", out_valid, 1'b0);
        step();
        check("post_rst_e2", out_valid, 1'b1);
        check("post_rst_data", out_data, 8'h3C);
        idle(2);
        drain(2);

        // randomized traffic
        act = 1'b0;
        val = 8'h00;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 4) == 0) act = !act;
            if ($urandom_range(0, 3) == 0) val = 8'($urandom_range(0, 255));
            if (act) drive(1'b0, 1'b0, ~val);
            else begin
                r = $urandom_range(0, 2);
                drive(r != 1, r != 2, ~val);
            end
            out_ready = ($urandom_range(0, 2) == 0);
            clr_overflow = ($urandom_range(0, 15) == 0);
            step();
        end
        clr_overflow = 1'b0;
        idle(2);
        drain(8);
        check("final_count", count, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edic_bus_receiver.md
Name: edic_bus_receiver

Overview:
- Receiving end of an inverting tri-state octal bus driver (74x540-style: two active-low enables, inverted outputs).
- Samples the shared bus and re-inverts the data.
- Requires the data to be stable for a configurable settle window before capturing it.
- Captures exactly one word per driver-enable window into a small first-word-fall-through FIFO, read out with a valid/ready handshake toward the EDiC control/register logic.

Parameters:
- WIDTH, 8, bus data width in bits.
- DEPTH, 4, FIFO depth in words; power of two, >= 2.
- SETTLE, 2, consecutive active sampled cycles of identical data required before capture; >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bus_n  input  WIDTH  inverted bus lines from the driver.
- oe1_n  input  1  driver enable 1, active low.
- oe2_n  input  1  driver enable 2, active low. The driver is active only when both enables are low.
- out_data  output  WIDTH  FIFO head (true polarity); 0 whenever out_valid = 0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head this cycle.
- count  output  $clog2(DEPTH)+1  words held in the FIFO.
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- clr_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Input stage:
  - bus_n, oe1_n and oe2_n are registered once (the s-stage).
  - data_s = ~bus_n_s; active_s = !oe1_n_s && !oe2_n_s.
  - After reset, the s-stage holds bus_n all ones and both enables high (inactive).
- FSM states: IDLE, SETTLE, HOLD. All transitions evaluate the s-stage values.
- IDLE:
  - If active_s: cand <= data_s, cnt <= 1.
  - If SETTLE == 1: push cand and go to HOLD.
  - Otherwise go to SETTLE.
- SETTLE:
  - If !active_s: go to IDLE; no capture (enable glitch).
  - Else if data_s != cand: cand <= data_s, cnt <= 1; stay in SETTLE.
  - Else cnt <= cnt+1. When cnt+1 == SETTLE: push cand and go to HOLD.
- HOLD:
  - Data changes are ignored.
  - If !active_s: go to IDLE. The next capture requires a new enable window.
- Latency: with bus and enables stable before edge E0 (the first sampling edge), out_valid rises after edge E(SETTLE) when the FIFO was empty.
- FIFO:
  - First-word fall-through.
  - Pop when out_valid && out_ready.
  - Push and pop on the same edge: both happen; count is unchanged, including when full.
  - Push when full without a pop: the word is dropped, count stays DEPTH, overflow <= 1.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- overflow:
  - Set by a dropped push; cleared by clr_overflow.
  - Set and clear on the same edge: set wins.
- Reset (asynchronous, any state, including mid-SETTLE):
  - FSM to IDLE; cnt = 0, cand = 0; pointers = 0.
  - out_valid = 0, out_data = 0, count = 0, overflow = 0.
  - The FIFO contents and any in-flight capture are discarded.
  - The first capture after reset requires a fresh, full settle window.

Optional Feature:
- Macro: EDIC_BUS_PARITY_CHECK_EN.
- When defined:
  - Extra input bus_par_n (1 bit): the inverted odd-parity line driven alongside bus_n. It is registered in the s-stage with the data.
  - Settle comparison covers data and parity together.
  - Each FIFO entry stores WIDTH+1 bits.
  - Extra output out_par_err (1 bit): high with out_valid when the head word and its parity bit do not have odd total parity; 0 when empty or after reset.
- When not defined: bus_par_n and out_par_err do not exist; FIFO width is WIDTH; behaviour is otherwise identical.

Test Plan:
- Reset, then oe1_n = oe2_n = 0, bus_n = 8'hA5 held 4 cycles, out_ready = 0 -> out_valid rises exactly after edge E2; out_data = 8'h5A; count = 1; one capture only.
- Enable window of 1 cycle only (SETTLE = 2) -> no capture, count stays 0. oe2_n high while oe1_n low and stable bus -> no capture.
- Bus changes 8'h00 -> 8'h0F in the middle of the settle window -> settle restarts; the single captured word is 8'hF0 (the re-inverted value of 8'h0F); the earlier value is never pushed.
- Five back-to-back enable windows with distinct data, out_ready = 0 (DEPTH = 4) -> count = 4 and overflow = 1. Then drain with out_ready = 1 -> the first four words come out in order. Asserting clr_overflow on the same edge as a fifth dropped push -> overflow remains 1.
- FIFO full with out_ready = 1 on the same edge as a push -> count stays 4, overflow stays 0, order preserved.
- Assert rst while in SETTLE with count = 2 -> all outputs 0 immediately (asynchronous). After release, a stable window captures normally with full SETTLE latency.
